// File: rtl/hazard_step_ctrl.sv
// Pipeline controller for the 5-stage MIPS core. It handles load-use and branch hazards,
// debug single-step sequencing, the halt drain, and the cycle and stall counters.
module hazard_step_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_IDEX_MEMREAD,
    input  logic [4:0]       I_IDEX_RT,
    input  logic [4:0]       I_ID_RS,
    input  logic [4:0]       I_ID_RT,
    input  logic             I_ID_USES_RT,
    input  logic             I_BRANCH_TAKEN,
    input  logic             I_ID_HALT,
    input  logic             I_DBG_MODE,
    input  logic             I_DBG_STEP,
    output logic             O_PIPE_EN,
    output logic             O_PC_WRITE,
    output logic             O_IFID_WRITE,
    output logic             O_IFID_FLUSH,
    output logic             O_IDEX_BUBBLE,
    output logic             O_HALTED,
    output logic [CNT_W-1:0] O_CYCLE_COUNT,
    output logic [CNT_W-1:0] O_STALL_COUNT
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP_EXEC,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic pipe_en;
    logic load_use;
    logic halt_accept;
    logic stall_apply;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Hazard resolution; everything is masked while the pipeline is frozen.
    always_comb begin
        pipe_en     = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC) || (state_q == ST_DRAIN);
        load_use    = I_IDEX_MEMREAD && (I_IDEX_RT != 5'd0) &&
                      ((I_IDEX_RT == I_ID_RS) || (I_ID_USES_RT && (I_IDEX_RT == I_ID_RT)));
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halt_accept = 1'b0;
        stall_apply = 1'b0;
        if (pipe_en) begin
            if (I_BRANCH_TAKEN) begin
                // Wrong-path halt or load-use in ID is discarded by the flush.
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (state_q == ST_DRAIN) begin
                ifid_flush  = 1'b1;
            end else if (I_ID_HALT) begin
                ifid_flush  = 1'b1;
                halt_accept = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
                stall_apply = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_accept) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (I_DBG_MODE) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (I_DBG_STEP) begin
                    state_d = ST_STEP_EXEC;
                end else if (!I_DBG_MODE) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP_EXEC: begin
                if (halt_accept) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (I_DBG_MODE) begin
                    state_d = ST_STEP_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Debug mode is ignored here so the halt always retires.
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pipe_en) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (stall_apply) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign O_PIPE_EN     = pipe_en;
    assign O_PC_WRITE    = pc_write;
    assign O_IFID_WRITE  = ifid_write;
    assign O_IFID_FLUSH  = ifid_flush;
    assign O_IDEX_BUBBLE = idex_bubble;
    assign O_HALTED      = (state_q == ST_HALTED);
    assign O_CYCLE_COUNT = cycle_cnt_q;
    assign O_STALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_step_ctrl.sv
// Directed bench for hazard_step_ctrl: expectations are queued as stimulus is applied
// and popped against the DUT outputs mid-cycle; a 4-bit counter instance covers wrap.
module tb_hazard_step_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        memread, uses_rt, br, halt, dbg_mode, dbg_step;
    logic [4:0]  idex_rt, id_rs, id_rt;

    logic        pe, pcw, ifw, flush, bub, halted;
    logic [31:0] cycle_cnt, stall_cnt;
    logic        s_pe, s_pcw, s_ifw, s_flush, s_bub, s_halted;
    logic [3:0]  s_cycle, s_stall;

    always #5 CLK = ~CLK;

    hazard_step_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_IDEX_MEMREAD(memread), .I_IDEX_RT(idex_rt), .I_ID_RS(id_rs), .I_ID_RT(id_rt),
        .I_ID_USES_RT(uses_rt), .I_BRANCH_TAKEN(br), .I_ID_HALT(halt),
        .I_DBG_MODE(dbg_mode), .I_DBG_STEP(dbg_step),
        .O_PIPE_EN(pe), .O_PC_WRITE(pcw), .O_IFID_WRITE(ifw), .O_IFID_FLUSH(flush),
        .O_IDEX_BUBBLE(bub), .O_HALTED(halted),
        .O_CYCLE_COUNT(cycle_cnt), .O_STALL_COUNT(stall_cnt)
    );

    hazard_step_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut_w4 (
        .CLK(CLK), .RESET(RESET),
        .I_IDEX_MEMREAD(memread), .I_IDEX_RT(idex_rt), .I_ID_RS(id_rs), .I_ID_RT(id_rt),
        .I_ID_USES_RT(uses_rt), .I_BRANCH_TAKEN(br), .I_ID_HALT(halt),
        .I_DBG_MODE(dbg_mode), .I_DBG_STEP(dbg_step),
        .O_PIPE_EN(s_pe), .O_PC_WRITE(s_pcw), .O_IFID_WRITE(s_ifw), .O_IFID_FLUSH(s_flush),
        .O_IDEX_BUBBLE(s_bub), .O_HALTED(s_halted),
        .O_CYCLE_COUNT(s_cycle), .O_STALL_COUNT(s_stall)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc_e  = 0;
    int   stall_e = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: obs = {31'd0, pe};
            1: obs = {31'd0, pcw};
            2: obs = {31'd0, ifw};
            3: obs = {31'd0, flush};
            4: obs = {31'd0, bub};
            5: obs = {31'd0, halted};
            6: obs = cycle_cnt;
            7: obs = stall_cnt;
            default: obs = {28'd0, s_cycle};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_ctl(input string tag, input logic e_pe, input logic e_pcw,
                           input logic e_ifw, input logic e_fl, input logic e_bub,
                           input logic e_h);
        push({tag, ".pipe_en"}, 0, {31'd0, e_pe});
        push({tag, ".pc_write"}, 1, {31'd0, e_pcw});
        push({tag, ".ifid_write"}, 2, {31'd0, e_ifw});
        push({tag, ".ifid_flush"}, 3, {31'd0, e_fl});
        push({tag, ".idex_bubble"}, 4, {31'd0, e_bub});
        push({tag, ".halted"}, 5, {31'd0, e_h});
    endtask

    task automatic exp_cnt(input string tag);
        push({tag, ".cycle_count"}, 6, cyc_e);
        push({tag, ".stall_count"}, 7, stall_e);
        push({tag, ".cycle_count_w4"}, 8, cyc_e % 16);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urt, input logic b,
                          input logic h);
        memread = mr;
        idex_rt = xrt;
        id_rs   = rs;
        id_rt   = rt;
        uses_rt = urt;
        br      = b;
        halt    = h;
    endtask

    task automatic cyc(input logic enabled);
        @(posedge CLK);
        #1;
        if (enabled) cyc_e++;
    endtask

    initial begin
        RESET    = 1'b1;
        dbg_mode = 1'b0;
        dbg_step = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        exp_ctl("reset", 1, 1, 1, 0, 0, 0);
        exp_cnt("reset");
        check();
        RESET = 1'b0;

        // Load-use: lw r5 in EX, ID reads r5 as rs.
        set_in(1, 5, 5, 0, 0, 0, 0);
        exp_ctl("lu_rs", 1, 0, 0, 0, 1, 0);
        check();
        cyc(1);
        stall_e++;
        set_in(0, 5, 5, 0, 0, 0, 0);
        exp_ctl("lu_after", 1, 1, 1, 0, 0, 0);
        exp_cnt("lu_after");
        check();
        cyc(1);
        set_in(1, 0, 0, 0, 1, 0, 0);
        exp_ctl("lu_r0", 1, 1, 1, 0, 0, 0);
        check();
        cyc(1);
        set_in(1, 7, 3, 7, 0, 0, 0);
        exp_ctl("lu_rt_unused", 1, 1, 1, 0, 0, 0);
        check();
        cyc(1);
        set_in(1, 7, 3, 7, 1, 0, 0);
        exp_ctl("lu_rt_used", 1, 0, 0, 0, 1, 0);
        check();
        cyc(1);
        stall_e++;

        // Branch takes priority over a load-use.
        set_in(1, 5, 5, 0, 0, 1, 0);
        exp_ctl("br_over_lu", 1, 1, 1, 1, 1, 0);
        exp_cnt("br_pre");
        check();
        cyc(1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        exp_cnt("br_post");
        check();

        // Single-step: enter STEP_WAIT, hazards masked while frozen.
        dbg_mode = 1'b1;
        exp_ctl("dbg_enter", 1, 1, 1, 0, 0, 0);
        check();
        cyc(1);
        set_in(1, 5, 5, 0, 0, 1, 0);
        exp_ctl("step_wait_mask", 0, 0, 0, 0, 0, 0);
        check();
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            dbg_step = 1'b1;
            exp_ctl("pulse_wait", 0, 0, 0, 0, 0, 0);
            check();
            cyc(0);
            dbg_step = 1'b0;
            exp_ctl("pulse_exec", 1, 1, 1, 0, 0, 0);
            check();
            cyc(1);
            for (int w = 0; w < 3; w++) begin
                push("pulse_idle.pipe_en", 0, 32'd0);
                check();
                cyc(0);
            end
        end
        exp_cnt("after_pulses");
        check();
        dbg_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push("held_step.pipe_en", 0, (i % 2 == 1) ? 32'd1 : 32'd0);
            check();
            cyc(i % 2 == 1);
        end
        dbg_step = 1'b0;
        dbg_mode = 1'b0;
        exp_cnt("after_held");
        push("drop_mode_wait.pipe_en", 0, 32'd0);
        check();
        cyc(0);
        exp_ctl("back_to_run", 1, 1, 1, 0, 0, 0);
        check();

        // Halt accepted at t; drain t+1..t+4; halted at t+5.
        set_in(0, 0, 0, 0, 0, 0, 1);
        exp_ctl("halt_accept", 1, 0, 0, 1, 0, 0);
        check();
        cyc(1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) set_in(1, 5, 5, 0, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0);
            exp_ctl("drain", 1, 0, 0, 1, 0, 0);
            check();
            cyc(1);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        exp_ctl("halted", 0, 0, 0, 0, 0, 1);
        exp_cnt("halted");
        check();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 5, 5, 0, 0, k[0], ~k[0]);
            cyc(0);
            exp_ctl("halted_frozen", 0, 0, 0, 0, 0, 1);
            exp_cnt("halted_frozen");
            check();
        end

        // Asynchronous reset out of HALTED, then again mid-drain.
        RESET = 1'b1;
        cyc_e = 0;
        stall_e = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        exp_ctl("rst_halted", 1, 1, 1, 0, 0, 0);
        exp_cnt("rst_halted");
        check();
        RESET = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1);
        cyc(1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        cyc(1);
        cyc(1);
        exp_ctl("mid_drain", 1, 0, 0, 1, 0, 0);
        check();
        RESET = 1'b1;
        cyc_e = 0;
        stall_e = 0;
        exp_ctl("rst_mid_drain", 1, 1, 1, 0, 0, 0);
        exp_cnt("rst_mid_drain");
        check();
        RESET = 1'b0;

        // 17 enabled cycles wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) cyc(1);
        push("wrap.cycle_count_w4", 8, 32'd1);
        push("wrap.cycle_count", 6, 32'd17);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_step_ctrl.md
Name: hazard_step_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Drives IF/ID write and flush, PC write and ID/EX bubble from load-use and taken-branch hazards.
- Sequences a global pipeline enable for debug single-step, and the halt drain that ends a program.
- Keeps cycle and stall counters for the debug unit.

Parameters:
- DRAIN_CYCLES, 4, number of enabled cycles between halt acceptance and HALTED (lets the halt instruction retire through EX/MEM/WB).
- CNT_W, 32, width of the cycle and stall counters.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high.
- I_IDEX_MEMREAD  in  1  instruction in EX is a load.
- I_IDEX_RT  in  5  destination register of the load in EX.
- I_ID_RS  in  5  rs field of the instruction in ID.
- I_ID_RT  in  5  rt field of the instruction in ID.
- I_ID_USES_RT  in  1  instruction in ID reads rt as a source.
- I_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX this cycle.
- I_ID_HALT  in  1  halt opcode decoded in ID.
- I_DBG_MODE  in  1  0 = continuous, 1 = single-step.
- I_DBG_STEP  in  1  step request, level sampled in STEP_WAIT.
- O_PIPE_EN  out  1  global enable for all pipeline registers, PC and register file writes.
- O_PC_WRITE  out  1  PC load enable.
- O_IFID_WRITE  out  1  IF/ID write enable.
- O_IFID_FLUSH  out  1  IF/ID loads NOP.
- O_IDEX_BUBBLE  out  1  ID/EX loads all-zero control (bubble).
- O_HALTED  out  1  program finished.
- O_CYCLE_COUNT  out  CNT_W  enabled cycles since reset.
- O_STALL_COUNT  out  CNT_W  load-use stall cycles since reset.

Behaviour:
- States: RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED.
- O_PIPE_EN = 1 in RUN, STEP_EXEC and DRAIN; 0 in STEP_WAIT and HALTED. It is a combinational decode of the state register.
- Hazard outputs are combinational and are all forced to 0 whenever O_PIPE_EN = 0. The other stages hold via O_PIPE_EN.
- Load-use condition (lu):
  - I_IDEX_MEMREAD
  - && I_IDEX_RT != 0
  - && (I_IDEX_RT == I_ID_RS || (I_ID_USES_RT && I_IDEX_RT == I_ID_RT)).
- Priority, highest first, in RUN, STEP_EXEC and DRAIN:
  1. I_BRANCH_TAKEN: PC_WRITE = 1, IFID_WRITE = 1, IFID_FLUSH = 1, IDEX_BUBBLE = 1. lu and I_ID_HALT are ignored because they are wrong path. This also applies in DRAIN, though no branch is expected there.
  2. DRAIN state: PC_WRITE = 0, IFID_WRITE = 0, IFID_FLUSH = 1, IDEX_BUBBLE = 0.
  3. I_ID_HALT, accepted in RUN or STEP_EXEC: PC_WRITE = 0, IFID_WRITE = 0, IFID_FLUSH = 1, IDEX_BUBBLE = 0. The halt instruction advances to EX. Next state is DRAIN, and the drain counter loads DRAIN_CYCLES-1.
  4. lu: PC_WRITE = 0, IFID_WRITE = 0, IFID_FLUSH = 0, IDEX_BUBBLE = 1. The stall counter increments.
  5. Otherwise: PC_WRITE = 1, IFID_WRITE = 1, IFID_FLUSH = 0, IDEX_BUBBLE = 0.
- Transitions:
  - RUN: go to DRAIN on halt acceptance; else go to STEP_WAIT if I_DBG_MODE = 1; else stay.
  - STEP_WAIT: go to STEP_EXEC if I_DBG_STEP; else go to RUN if I_DBG_MODE = 0; else stay.
  - STEP_EXEC lasts exactly one enabled cycle. Then go to DRAIN on halt acceptance; else go to STEP_WAIT if I_DBG_MODE = 1; else RUN. A held I_DBG_STEP therefore advances one instruction every 2 cycles.
  - DRAIN: the counter decrements every cycle regardless of I_DBG_MODE. Go to HALTED when it is 0 at the clock edge, so DRAIN lasts DRAIN_CYCLES cycles.
  - HALTED: terminal; left only by RESET.
- Halt latency: DRAIN_CYCLES+1 cycles from the halt-acceptance cycle to O_HALTED = 1.
- O_HALTED = 1 only in HALTED (state decode).
- A load-use stall in the halt-acceptance cycle is superseded by the halt. The halt instruction itself carries no sources, so this is a don't-care.
- Counters:
  - O_CYCLE_COUNT increments on every edge where O_PIPE_EN = 1.
  - O_STALL_COUNT increments on every edge where the lu stall is applied.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset, asynchronous and allowed at any time including mid-DRAIN or mid-step:
  - state = RUN, drain counter = 0, both counters = 0.
  - With no hazards the outputs are O_PIPE_EN = 1, O_PC_WRITE = 1, O_IFID_WRITE = 1, O_IFID_FLUSH = 0, O_IDEX_BUBBLE = 0, O_HALTED = 0.

Test Plan:
1. Load-use stall: lw with I_IDEX_RT = 5 in EX, ID with I_ID_RS = 5 -> exactly 1 cycle of PC_WRITE = 0, IFID_WRITE = 0, IDEX_BUBBLE = 1; O_STALL_COUNT 0 -> 1. The same case with I_IDEX_RT = 0, or with an rt match and I_ID_USES_RT = 0 -> no stall.
2. Branch over stall: I_BRANCH_TAKEN = 1 together with lu = 1 -> IFID_FLUSH = 1, IDEX_BUBBLE = 1, PC_WRITE = 1, stall counter unchanged.
3. Halt drain with DRAIN_CYCLES = 4: I_ID_HALT at cycle t -> PC_WRITE = 0 and IFID_FLUSH = 1 from t through t+4. O_HALTED rises at t+5. O_PIPE_EN = 0 and O_CYCLE_COUNT frozen thereafter, even with I_BRANCH_TAKEN/I_ID_HALT toggled.
4. Single-step: I_DBG_MODE = 1, then three 1-cycle I_DBG_STEP pulses spaced 5 cycles apart -> O_PIPE_EN high for exactly 3 cycles and O_CYCLE_COUNT increases by exactly 3. Held I_DBG_STEP for 10 cycles -> 5 enabled cycles. Dropping I_DBG_MODE in STEP_WAIT -> RUN the next cycle.
5. Reset mid-DRAIN (2 cycles after halt acceptance) -> immediately state RUN, O_HALTED = 0, counters 0, O_PC_WRITE = 1 with no clock edge required.
6. Counter wrap with CNT_W = 4: 17 enabled cycles -> O_CYCLE_COUNT = 1.
